branch_history_table: RTL and testbench
=======================================

// Module: branch_history_table
// PURPOSE
//  PC-indexed table of saturating branch counters for the 5-stage MIPS pipeline.
//  IF reads a taken/not-taken prediction for the fetch PC in the same cycle.
//  ID writes the resolved outcome once the comparator decides the branch.
//  Generalises the fixed not-taken policy (always flush IF on a taken branch) to
//  configurable depth and counter width, and adds a misprediction statistic.
// PARAMETERS
//  ENTRIES     64  number of table entries; power of 2, >= 2; INDEX_BITS = log2(ENTRIES)
//  CTR_WIDTH    2  bits per saturating counter; range 1..4
//  PC_WIDTH    32  width of all PC and target buses
//  TAG_WIDTH    8  partial-tag bits per entry; used only with BHT_TARGET_EN
//  STAT_WIDTH  16  width of the MispredictCount register
// PORTS
//  Clk              in   1          rising-edge clock
//  reset            in   1          asynchronous, active-high reset
//  LookupPC         in   PC_WIDTH   PC of the instruction in IF
//  PredTaken        out  1          prediction for LookupPC (combinational)
//  PredHit          out  1          entry valid for LookupPC (combinational)
//  PredTarget       out  PC_WIDTH   predicted target for LookupPC (combinational)
//  Clear            in   1          synchronous re-initialise of the whole table
//  UpdateValid      in   1          a resolved branch is presented this cycle
//  UpdatePC         in   PC_WIDTH   PC of the resolved branch
//  UpdateTaken      in   1          resolved direction
//  UpdateTarget     in   PC_WIDTH   resolved target address
//  UpdateMispredict in   1          ID found that the IF prediction was wrong
//  MispredictCount  out  STAT_WIDTH number of mispredictions, saturating
// BEHAVIOUR
//  - Index = PC[INDEX_BITS+1:2]. Word-aligned PCs; PC[1:0] are ignored.
//  - Reset (async) and Clear (sync):
//    - every counter = WNT = 2^(CTR_WIDTH-1)-1 (2'b01 when CTR_WIDTH=2).
//    - all valid bits and tags = 0.
//    - MispredictCount = 0 on reset only; Clear does not change it.
//  - Lookup (combinational from table state):
//    - PredTaken = counter[idx] MSB, gated by PredHit.
//    - Latency 0, so IF can select the next PC in the same cycle.
//  - Update (at the rising edge when UpdateValid=1):
//    - Counter moves +1 if UpdateTaken, -1 if not.
//    - Saturates at 2^CTR_WIDTH-1 and at 0. No wrap-around.
//  - Stat: if UpdateValid & UpdateMispredict, MispredictCount += 1, saturating at all-ones.
//  - UpdateMispredict with UpdateValid=0 is ignored.
//  - Lookup and update to the same index in the same cycle: lookup returns the
//    pre-update value (no bypass). The new value is visible next cycle.
//  - Clear and UpdateValid in the same cycle:
//    - Clear wins for the table.
//    - MispredictCount still counts the update.
//  - reset asserted mid-update: the table returns to reset values immediately;
//    the update is lost.
//  - CTR_WIDTH=1: a last-outcome predictor. The reset value is 0 (not taken).
// CONFIGURATION
//  BHT_TARGET_EN defined:
//    - Each entry also holds a valid bit, TAG_WIDTH tag bits
//      (PC[INDEX_BITS+1+TAG_WIDTH:INDEX_BITS+2]) and a PC_WIDTH target.
//    - PredHit = valid & tag match. PredTaken = PredHit & counter MSB.
//      PredTarget = stored target.
//    - On an update where the stored tag differs or the entry is invalid:
//      - write the tag, set valid, store UpdateTarget;
//      - counter = WNT+1 if taken, else WNT.
//    - On a tag hit with UpdateTaken=1: the target is overwritten.
//  BHT_TARGET_EN undefined:
//    - No tag, valid or target storage.
//    - PredHit = 1 and PredTarget = 0. PredTaken = counter MSB.
// TESTING
//  1. Reset, then look up any PC -> PredTaken=0, MispredictCount=0.
//     With BHT_TARGET_EN: PredHit=0.
//  2. 3 updates taken @PC=0x40 -> counter 01->10->11->11 (saturated).
//     LookupPC=0x40 gives PredTaken=1.
//     Then 1 update not-taken -> 10, still taken; a second -> 01, not taken.
//  3. Aliasing: ENTRIES=64, update taken x2 @0x40.
//     -> LookupPC=0x140 (same index) PredTaken=1 without the macro.
//     With the macro: PredHit=0.
//  4. Same-cycle update and lookup @0x80 from 01 with UpdateTaken=1
//     -> PredTaken=0 that cycle, 1 next cycle.
//  5. Clear with UpdateValid=1 and UpdateMispredict=1 in the same cycle
//     -> all entries WNT, MispredictCount +1.
//     65535 further mispredicts (STAT_WIDTH=16) -> held at 16'hFFFF.
//  6. BHT_TARGET_EN: taken update @0x40 with target 0x200
//     -> LookupPC=0x40 gives PredHit=1, PredTarget=0x200, PredTaken=1 (counter 10).
//     Assert reset mid-run -> PredHit=0 immediately.

Source files
------------

// File: rtl/branch_history_table.sv
// PC-indexed saturating-counter branch predictor with misprediction statistic.
// Optional per-entry valid/tag/target storage enabled by defining BHT_TARGET_EN.
`timescale 1ns/1ps
module branch_history_table #(
    parameter int ENTRIES    = 64,
    parameter int CTR_WIDTH  = 2,
    parameter int PC_WIDTH   = 32,
    parameter int TAG_WIDTH  = 8,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic [PC_WIDTH-1:0]   LookupPC,
    output logic                  PredTaken,
    output logic                  PredHit,
    output logic [PC_WIDTH-1:0]   PredTarget,
    input  logic                  Clear,
    input  logic                  UpdateValid,
    input  logic [PC_WIDTH-1:0]   UpdatePC,
    input  logic                  UpdateTaken,
    input  logic [PC_WIDTH-1:0]   UpdateTarget,
    input  logic                  UpdateMispredict,
    output logic [STAT_WIDTH-1:0] MispredictCount
);

    localparam int INDEX_BITS = $clog2(ENTRIES);
    localparam logic [CTR_WIDTH-1:0] WNT =
        CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

    logic [CTR_WIDTH-1:0]  r_ctr [ENTRIES];
    logic [STAT_WIDTH-1:0] r_stat;

    logic [INDEX_BITS-1:0] w_lk_idx;
    logic [INDEX_BITS-1:0] w_up_idx;
    logic [CTR_WIDTH-1:0]  w_lk_ctr;
    logic [CTR_WIDTH-1:0]  w_up_ctr;
    logic [CTR_WIDTH-1:0]  w_ctr_step;
    logic [CTR_WIDTH-1:0]  w_ctr_next;
    logic                  w_unused;

    assign w_lk_idx = LookupPC[INDEX_BITS+1:2];
    assign w_up_idx = UpdatePC[INDEX_BITS+1:2];
    assign w_lk_ctr = r_ctr[w_lk_idx];
    assign w_up_ctr = r_ctr[w_up_idx];

    // Whole buses are folded here so bits outside index/tag fields are accounted for.
    assign w_unused = ^{LookupPC, UpdatePC, UpdateTarget};

    // Saturating +1/-1 step of the counter selected by the resolved branch.
    always_comb begin
        w_ctr_step = w_up_ctr;
        if (UpdateTaken) begin
            if (w_up_ctr != CTR_MAX)
                w_ctr_step = w_up_ctr + CTR_WIDTH'(1);
        end else begin
            if (w_up_ctr != '0)
                w_ctr_step = w_up_ctr - CTR_WIDTH'(1);
        end
    end

`ifdef BHT_TARGET_EN
    logic                  r_valid  [ENTRIES];
    logic [TAG_WIDTH-1:0]  r_tag    [ENTRIES];
    logic [PC_WIDTH-1:0]   r_target [ENTRIES];

    logic [TAG_WIDTH-1:0]  w_lk_tag;
    logic [TAG_WIDTH-1:0]  w_up_tag;
    logic                  w_lk_hit;
    logic                  w_up_hit;

    assign w_lk_tag = LookupPC[INDEX_BITS+1+TAG_WIDTH:INDEX_BITS+2];
    assign w_up_tag = UpdatePC[INDEX_BITS+1+TAG_WIDTH:INDEX_BITS+2];
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    assign PredHit    = w_lk_hit;
    assign PredTaken  = w_lk_hit & w_lk_ctr[CTR_WIDTH-1];
    assign PredTarget = r_target[w_lk_idx];

    // A tag miss reallocates the entry with a weak counter biased by the outcome.
    always_comb begin
        w_ctr_next = w_ctr_step;
        if (!w_up_hit)
            w_ctr_next = UpdateTaken ? WNT + CTR_WIDTH'(1) : WNT;
    end

    // Table state: async reset, sync clear (wins over update), then update.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i]    <= WNT;
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (Clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i]    <= WNT;
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (UpdateValid) begin
            r_ctr[w_up_idx] <= w_ctr_next;
            if (!w_up_hit) begin
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= UpdateTarget;
            end else if (UpdateTaken) begin
                r_target[w_up_idx] <= UpdateTarget;
            end
        end
    end
`else
    assign PredHit    = 1'b1;
    assign PredTaken  = w_lk_ctr[CTR_WIDTH-1];
    assign PredTarget = '0;
    assign w_ctr_next = w_ctr_step;

    // Counter table: async reset, sync clear (wins over update), then update.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++)
                r_ctr[i] <= WNT;
        end else if (Clear) begin
            for (int i = 0; i < ENTRIES; i++)
                r_ctr[i] <= WNT;
        end else if (UpdateValid) begin
            r_ctr[w_up_idx] <= w_ctr_next;
        end
    end
`endif

    // Misprediction statistic: cleared only by reset, saturates at all-ones.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset)
            r_stat <= '0;
        else if (UpdateValid && UpdateMispredict && (r_stat != '1))
            r_stat <= r_stat + STAT_WIDTH'(1);
    end

    assign MispredictCount = r_stat;

endmodule

// File: tb/tb_branch_history_table.sv
// Directed testbench for branch_history_table (default 64 x 2-bit, 16-bit stat).
// Expectations for the BHT_TARGET_EN build are selected by the same macro.
`timescale 1ns/1ps
module tb_branch_history_table;

    logic        Clk;
    logic        reset;
    logic [31:0] LookupPC;
    logic        PredTaken;
    logic        PredHit;
    logic [31:0] PredTarget;
    logic        Clear;
    logic        UpdateValid;
    logic [31:0] UpdatePC;
    logic        UpdateTaken;
    logic [31:0] UpdateTarget;
    logic        UpdateMispredict;
    logic [15:0] MispredictCount;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_cnt = 16'd0;

    branch_history_table dut (
        .Clk(Clk),
        .reset(reset),
        .LookupPC(LookupPC),
        .PredTaken(PredTaken),
        .PredHit(PredHit),
        .PredTarget(PredTarget),
        .Clear(Clear),
        .UpdateValid(UpdateValid),
        .UpdatePC(UpdatePC),
        .UpdateTaken(UpdateTaken),
        .UpdateTarget(UpdateTarget),
        .UpdateMispredict(UpdateMispredict),
        .MispredictCount(MispredictCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One resolved branch, presented for a single clock edge.
    task automatic do_update(input logic [31:0] pc, input logic tk,
                             input logic [31:0] tgt, input logic mis);
        UpdateValid      = 1'b1;
        UpdatePC         = pc;
        UpdateTaken      = tk;
        UpdateTarget     = tgt;
        UpdateMispredict = mis;
        @(posedge Clk);
        if (mis && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        @(negedge Clk);
        UpdateValid      = 1'b0;
        UpdateMispredict = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge Clk);
        reset = 1'b0;
        LookupPC = 32'h40;
        #1;
        checks++;
        if (PredTaken !== 1'b0) begin
            errors++;
            $display("FAIL reset_taken: got %b want 0", PredTaken);
        end
        checks++;
        if (MispredictCount !== 16'd0) begin
            errors++;
            $display("FAIL reset_count: got %h want 0", MispredictCount);
        end
`ifdef BHT_TARGET_EN
        checks++;
        if (PredHit !== 1'b0) begin
            errors++;
            $display("FAIL reset_hit: got %b want 0", PredHit);
        end
`else
        checks++;
        if (PredHit !== 1'b1 || PredTarget !== 32'd0) begin
            errors++;
            $display("FAIL reset_hit_tgt: got %b/%h want 1/0", PredHit, PredTarget);
        end
`endif
    endtask

    task automatic test_saturate;
        logic exp_seq [10];
        logic tk_seq  [10];
        // 01 ->T10 ->T11 ->T11 ->N10 ->N01 ->N00 ->N00 ->N00 ->T01 ->T10
        tk_seq  = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
        exp_seq = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
        LookupPC = 32'h40;
        for (int i = 0; i < 10; i++) begin
            do_update(32'h40, tk_seq[i], 32'h0, 1'b0);
            #1;
            checks++;
            if (PredTaken !== exp_seq[i]) begin
                errors++;
                $display("FAIL saturate_step%0d: got %b want %b", i, PredTaken, exp_seq[i]);
            end
        end
    endtask

    task automatic test_mispredict_gate;
        UpdateMispredict = 1'b1;
        UpdateValid = 1'b0;
        @(negedge Clk);
        UpdateMispredict = 1'b0;
        #1;
        checks++;
        if (MispredictCount !== 16'd0) begin
            errors++;
            $display("FAIL mis_no_valid: got %h want 0", MispredictCount);
        end
        do_update(32'h1000, 1'b0, 32'h0, 1'b1);
        #1;
        checks++;
        if (MispredictCount !== 16'd1) begin
            errors++;
            $display("FAIL mis_counted: got %h want 1", MispredictCount);
        end
    endtask

    task automatic test_alias;
        Clear = 1'b1;
        @(negedge Clk);
        Clear = 1'b0;
        LookupPC = 32'h40;
        #1;
        checks++;
        if (PredTaken !== 1'b0) begin
            errors++;
            $display("FAIL clear_only: got %b want 0", PredTaken);
        end
        do_update(32'h40, 1'b1, 32'h0, 1'b0);
        do_update(32'h40, 1'b1, 32'h0, 1'b0);
        LookupPC = 32'h140;
        #1;
`ifdef BHT_TARGET_EN
        checks++;
        if (PredHit !== 1'b0 || PredTaken !== 1'b0) begin
            errors++;
            $display("FAIL alias_hit: got %b/%b want 0/0", PredHit, PredTaken);
        end
`else
        checks++;
        if (PredTaken !== 1'b1) begin
            errors++;
            $display("FAIL alias_taken: got %b want 1", PredTaken);
        end
`endif
        LookupPC = 32'h40;
        #1;
        checks++;
        if (PredTaken !== 1'b1) begin
            errors++;
            $display("FAIL alias_home: got %b want 1", PredTaken);
        end
    endtask

    task automatic test_same_cycle;
        LookupPC = 32'h80;
        UpdateValid = 1'b1;
        UpdatePC = 32'h80;
        UpdateTaken = 1'b1;
        UpdateTarget = 32'h0;
        #1;
        checks++;
        if (PredTaken !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_pre: got %b want 0", PredTaken);
        end
        @(negedge Clk);
        UpdateValid = 1'b0;
        #1;
        checks++;
        if (PredTaken !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_post: got %b want 1", PredTaken);
        end
    endtask

    task automatic test_clear_stat;
        Clear = 1'b1;
        do_update(32'h40, 1'b1, 32'h0, 1'b1);
        Clear = 1'b0;
        LookupPC = 32'h40;
        #1;
        checks++;
        if (PredTaken !== 1'b0) begin
            errors++;
            $display("FAIL clear_wins_40: got %b want 0", PredTaken);
        end
        LookupPC = 32'h80;
        #1;
        checks++;
        if (PredTaken !== 1'b0) begin
            errors++;
            $display("FAIL clear_wins_80: got %b want 0", PredTaken);
        end
        checks++;
        if (MispredictCount !== 16'd2) begin
            errors++;
            $display("FAIL clear_counts: got %h want 0002", MispredictCount);
        end
        UpdateValid = 1'b1;
        UpdatePC = 32'h40;
        UpdateTaken = 1'b1;
        UpdateMispredict = 1'b1;
        repeat (65532) @(posedge Clk);
        exp_cnt = 16'hFFFE;
        @(negedge Clk);
        checks++;
        if (MispredictCount !== exp_cnt) begin
            errors++;
            $display("FAIL stat_near_max: got %h want %h", MispredictCount, exp_cnt);
        end
        @(posedge Clk);
        exp_cnt = 16'hFFFF;
        @(negedge Clk);
        checks++;
        if (MispredictCount !== exp_cnt) begin
            errors++;
            $display("FAIL stat_max: got %h want %h", MispredictCount, exp_cnt);
        end
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        UpdateValid = 1'b0;
        UpdateMispredict = 1'b0;
        checks++;
        if (MispredictCount !== 16'hFFFF) begin
            errors++;
            $display("FAIL stat_hold: got %h want ffff", MispredictCount);
        end
    endtask

    task automatic test_reset_mid;
        LookupPC = 32'h40;
        #1;
        checks++;
        if (PredTaken !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got %b want 1", PredTaken);
        end
        UpdateValid = 1'b1;
        UpdatePC = 32'h40;
        UpdateTaken = 1'b1;
        UpdateMispredict = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (PredTaken !== 1'b0 || MispredictCount !== 16'd0) begin
            errors++;
            $display("FAIL reset_async: got %b/%h want 0/0000", PredTaken, MispredictCount);
        end
`ifdef BHT_TARGET_EN
        checks++;
        if (PredHit !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_hit: got %b want 0", PredHit);
        end
`endif
        @(negedge Clk);
        UpdateValid = 1'b0;
        UpdateMispredict = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (PredTaken !== 1'b0 || MispredictCount !== 16'd0) begin
            errors++;
            $display("FAIL reset_update_lost: got %b/%h want 0/0000", PredTaken, MispredictCount);
        end
        exp_cnt = 16'd0;
    endtask

    task automatic test_target;
`ifdef BHT_TARGET_EN
        do_update(32'h40, 1'b1, 32'h200, 1'b0);
        LookupPC = 32'h40;
        #1;
        checks++;
        if (PredHit !== 1'b1 || PredTarget !== 32'h200 || PredTaken !== 1'b1) begin
            errors++;
            $display("FAIL target_alloc: got %b/%h/%b want 1/200/1", PredHit, PredTarget, PredTaken);
        end
        do_update(32'h40, 1'b0, 32'h300, 1'b0);
        #1;
        checks++;
        if (PredTarget !== 32'h200 || PredTaken !== 1'b0) begin
            errors++;
            $display("FAIL target_keep: got %h/%b want 200/0", PredTarget, PredTaken);
        end
        do_update(32'h40, 1'b1, 32'h300, 1'b0);
        #1;
        checks++;
        if (PredTarget !== 32'h300 || PredTaken !== 1'b1) begin
            errors++;
            $display("FAIL target_overwrite: got %h/%b want 300/1", PredTarget, PredTaken);
        end
`else
        do_update(32'h7C, 1'b1, 32'h200, 1'b0);
        LookupPC = 32'h7C;
        #1;
        checks++;
        if (PredHit !== 1'b1 || PredTarget !== 32'h0 || PredTaken !== 1'b1) begin
            errors++;
            $display("FAIL notarget: got %b/%h/%b want 1/0/1", PredHit, PredTarget, PredTaken);
        end
`endif
    endtask

    initial begin
        reset = 1'b1;
        LookupPC = 32'h0;
        Clear = 1'b0;
        UpdateValid = 1'b0;
        UpdatePC = 32'h0;
        UpdateTaken = 1'b0;
        UpdateTarget = 32'h0;
        UpdateMispredict = 1'b0;
        test_reset();
        test_saturate();
        test_mispredict_gate();
        test_alias();
        test_same_cycle();
        test_clear_stat();
        test_reset_mid();
        test_target();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
